xunit_sha256_compress: RTL
==========================

Name: xunit_sha256_compress

Overview:
SHA-256 compression stage. It sits directly downstream of the message-schedule unit and consumes its W_t stream, one 32-bit word per cycle for 64 rounds. It holds the chaining hash H0..H7 and the working variables a..h across rounds, then streams the updated digest out serially. It is a Versat functional unit with the same run/delay configuration style as its schedule-unit neighbour.

Parameters:
DELAY_W, 10, width of the Versat delay bus (unit uses low 8 bits of delay0)
DATA_W, 32, datapath width; only 32 is supported

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
run  in  1  single-cycle start pulse for one 512-bit block
in0  in  DATA_W  W_t from the schedule unit, sampled once per round cycle
init0  in  1  config: 1 = reload H with the SHA-256 IV at run; 0 = chain from the previous block
delay0  in  8  config: idle cycles between run and the first W_t sample
out0  out  DATA_W  registered digest word stream H0..H7
done  out  1  high once the digest stream has completed; cleared by run

Behaviour:
- Reset (rst=0, async): state IDLE; out0=0, done=0; H0..H7=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); a..h=0; counters=0.
- States: IDLE, WAIT, ROUND, ADD, OUT.
- run=1 in any state has top priority:
  - delay <= delay0; done <= 0.
  - If init0=1: H <= IV and a..h <= IV in the same edge. Otherwise a..h <= current H.
  - Next state is WAIT if delay0!=0, else ROUND.
  - A run during WAIT/ROUND/ADD/OUT abandons the block. H is untouched unless ADD already committed.
- WAIT: delay decrements each cycle. On the cycle delay reaches 1, the next state is ROUND.
- ROUND: round counter t runs 0..63, one round per cycle.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + in0.
  - T2 = Σ0(a) + Maj(a,b,c).
  - h..a <= g,f,e,d+T1,c,b,a,T1+T2. All sums are modulo 2^32.
  - in0 is sampled on the ROUND cycle with counter t as W_t. The first W is therefore sampled on the cycle after run when delay0=0, or delay0+1 cycles after run otherwise.
  - After t=63, next state is ADD.
- ADD (1 cycle): Hi <= Hi + working_i (mod 2^32); next state OUT.
- OUT (8 cycles, j=0..7): out0 <= H[j] on each edge. out0 therefore shows H0 on the first cycle after entering OUT and H7 eight cycles after entering OUT.
  - After j=7, done <= 1 and next state is IDLE. out0 holds H7.
- Latency: run to first digest word = delay0 + 66 cycles. Run to done = delay0 + 74 cycles.
- IDLE: in0 is ignored, H is retained, and out0/done hold their values.
- Multi-block messages: issue run with init0=0 after done. A run with init0=0 while done=0 (block abandoned before ADD) chains from the last committed H.
- Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25; Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).

Decomposition:
- Package sha256_pkg holds:
  - K[0..63] constant table and the IV[0..7] constants.
  - State encoding for IDLE/WAIT/ROUND/ADD/OUT.
  - Functions ROTR, Σ0, Σ1, Ch, Maj.
- Sub-module sha256_round: purely combinational single round. Inputs are a..h, K, W; outputs are next a..h. It is instantiated once. The FSM, counters, H registers and output mux stay in the top.

Test Plan:
1. "abc", init0=1, delay0=0, bench drives the 64 precomputed W_t -> out0 stream ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; first word at run+66; done at run+74.
2. Empty message (W0=80000000, rest from padding), init0=1, delay0=5 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; first word at run+71.
3. Two-block "abcdbcdecdefdefg...nopq": block1 init0=1, block2 init0=0 after done -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
4. Abort: run "abc", re-issue run at round t=30 with init0=1, then rerun the full "abc" block -> same digest as test 1; done never asserts for the aborted block.
5. Async reset: drive rst=0 mid-ROUND, asynchronously between clock edges -> out0=0, done=0, H=IV immediately. Then "abc" with init0=0 -> test-1 digest, proving H was reset to IV.
6. After test 1, hold in0 random and run=0 for 100 cycles -> out0 stays f20015ad, done stays 1, no H change.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state encoding and bitwise round functions
// for the compression unit and its combinational round.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ROUND,
        ST_ADD,
        ST_OUT
    } state_t;

    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: current working variables plus K_t and W_t
// in, next working variables out.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] f,
    input  logic [31:0] g,
    input  logic [31:0] h,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output logic [31:0] a_next,
    output logic [31:0] b_next,
    output logic [31:0] c_next,
    output logic [31:0] d_next,
    output logic [31:0] e_next,
    output logic [31:0] f_next,
    output logic [31:0] g_next,
    output logic [31:0] h_next
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign a_next = t1 + t2;
    assign b_next = a;
    assign c_next = b;
    assign d_next = c;
    assign e_next = d + t1;
    assign f_next = e;
    assign g_next = f;
    assign h_next = g;

endmodule

// File: rtl/xunit_sha256_compress.sv
// SHA-256 compression Versat unit: consumes W_t for 64 rounds, folds the result
// into the chaining hash, then streams H0..H7 out serially on out0.
module xunit_sha256_compress
    import sha256_pkg::*;
#(
    parameter int DELAY_W = 10,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic              init0,
    input  logic [7:0]        delay0,
    output logic [DATA_W-1:0] out0,
    output logic              done
);

    state_t             state;
    state_t             state_next;
    logic [DELAY_W-1:0] delay;
    logic [5:0]         round;
    logic [3:0]         idx;
    word_t              hash [8];
    work_t              work;
    work_t              work_next;

    sha256_round u_round (
        .a      (work.a),
        .b      (work.b),
        .c      (work.c),
        .d      (work.d),
        .e      (work.e),
        .f      (work.f),
        .g      (work.g),
        .h      (work.h),
        .k      (K[round]),
        .w      (in0),
        .a_next (work_next.a),
        .b_next (work_next.b),
        .c_next (work_next.c),
        .d_next (work_next.d),
        .e_next (work_next.e),
        .f_next (work_next.f),
        .g_next (work_next.g),
        .h_next (work_next.h)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (run) begin
            state_next = (delay0 != '0) ? ST_WAIT : ST_ROUND;
        end else begin
            case (state)
                ST_IDLE:  state_next = ST_IDLE;
                ST_WAIT:  if (delay == DELAY_W'(1)) state_next = ST_ROUND;
                ST_ROUND: if (round == 6'd63) state_next = ST_ADD;
                ST_ADD:   state_next = ST_OUT;
                ST_OUT:   if (idx == 4'd8) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delay <= '0;
            round <= '0;
            idx   <= '0;
            out0  <= '0;
            done  <= 1'b0;
            work  <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                hash[i] <= IV[i];
            end
        end else if (run) begin
            delay <= DELAY_W'(delay0);
            round <= '0;
            idx   <= '0;
            done  <= 1'b0;
            if (init0) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    hash[i] <= IV[i];
                end
                work <= {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};
            end else begin
                work <= {hash[0], hash[1], hash[2], hash[3],
                         hash[4], hash[5], hash[6], hash[7]};
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    delay <= delay - DELAY_W'(1);
                end
                ST_ROUND: begin
                    work  <= work_next;
                    round <= round + 6'd1;
                end
                ST_ADD: begin
                    hash[0] <= hash[0] + work.a;
                    hash[1] <= hash[1] + work.b;
                    hash[2] <= hash[2] + work.c;
                    hash[3] <= hash[3] + work.d;
                    hash[4] <= hash[4] + work.e;
                    hash[5] <= hash[5] + work.f;
                    hash[6] <= hash[6] + work.g;
                    hash[7] <= hash[7] + work.h;
                end
                ST_OUT: begin
                    // Eight word slots, then one extra slot to raise done while out0 keeps H7.
                    if (idx == 4'd8) begin
                        done <= 1'b1;
                        idx  <= '0;
                    end else begin
                        out0 <= hash[idx[2:0]];
                        idx  <= idx + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
